// File: rtl/us_timer_pkg.sv
// us_timer_pkg: shared types and helpers for the microsecond timer bank
package us_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

    typedef logic [15:0] count_t;

    // bits needed to hold 0..value-1, never less than one
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/us_prescaler.sv
// us_prescaler: free-running divider producing a one-cycle pulse every microsecond
module us_prescaler
    import us_timer_pkg::*;
#(
    parameter int CLKS_PER_US = 50
) (
    input  logic sysclk,
    input  logic sysreset_n,
    output logic us_tick
);

    localparam int PW = clog2(CLKS_PER_US);
    localparam logic [PW-1:0] LAST = PW'(CLKS_PER_US - 1);

    logic [PW-1:0] phase = '0;

    // count 0..CLKS_PER_US-1 and wrap; loads never restart it
    always_ff @(posedge sysclk) begin
        if (!sysreset_n) phase <= '0;
        else phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end

    assign us_tick = (phase == LAST);

endmodule

// File: rtl/us_timer_bank.sv
// us_timer_bank: bank of independent microsecond countdown timers with per-timer expiry events
// Optional periodic auto-reload is enabled by defining US_TIMER_AUTORELOAD_EN.
module us_timer_bank
    import us_timer_pkg::*;
#(
    parameter int NUM_TIMERS  = 4,
    parameter int CLKS_PER_US = 50
) (
    input  logic                  sysclk,
    input  logic                  sysreset_n,
    input  logic [15:0]           data_in,
    input  logic [NUM_TIMERS-1:0] load,
    input  logic [NUM_TIMERS-1:0] periodic,
    input  logic [3:0]            read_select,
    output logic [15:0]           count_out,
    output logic [NUM_TIMERS-1:0] expired
);

    logic   us_tick;
    count_t counts [NUM_TIMERS];
    count_t sel_count;
    count_t count_out_q = '0;

    us_prescaler #(.CLKS_PER_US(CLKS_PER_US)) u_prescaler (
        .sysclk    (sysclk),
        .sysreset_n(sysreset_n),
        .us_tick   (us_tick)
    );

`ifndef US_TIMER_AUTORELOAD_EN
    logic unused_periodic;
    assign unused_periodic = ^periodic;
`endif

    for (genvar t = 0; t < NUM_TIMERS; t++) begin : g_timer
        timer_state_t state_q = IDLE;
        count_t       count_q = '0;
        logic         exp_q   = 1'b0;
`ifdef US_TIMER_AUTORELOAD_EN
        count_t       reload_q = '0;
        logic         mode_q   = 1'b0;
`endif

        // load beats a coincident tick; a zero load expires immediately
        always_ff @(posedge sysclk) begin
            if (!sysreset_n) begin
                state_q <= IDLE;
                count_q <= '0;
                exp_q   <= 1'b0;
`ifdef US_TIMER_AUTORELOAD_EN
                reload_q <= '0;
                mode_q   <= 1'b0;
`endif
            end else if (load[t]) begin
                state_q <= (data_in == '0) ? EXPIRED : RUNNING;
                count_q <= data_in;
                exp_q   <= (data_in == '0);
`ifdef US_TIMER_AUTORELOAD_EN
                reload_q <= data_in;
                mode_q   <= periodic[t];
`endif
            end else if (state_q == RUNNING) begin
                exp_q <= 1'b0;
                if (us_tick) begin
                    if (count_q > 16'd1) begin
                        count_q <= count_q - 16'd1;
`ifdef US_TIMER_AUTORELOAD_EN
                    end else if (mode_q) begin
                        count_q <= reload_q;
                        exp_q   <= 1'b1;
`endif
                    end else begin
                        count_q <= '0;
                        state_q <= EXPIRED;
                        exp_q   <= 1'b1;
                    end
                end
            end
        end

        assign counts[t]  = count_q;
        assign expired[t] = exp_q;
    end

    // select the addressed timer; out-of-range indices read as zero
    always_comb begin
        sel_count = '0;
        for (int k = 0; k < NUM_TIMERS; k++)
            if (read_select == 4'(k)) sel_count = counts[k];
    end

    // register the readback so it is glitch-free and one cycle behind
    always_ff @(posedge sysclk) begin
        if (!sysreset_n) count_out_q <= '0;
        else count_out_q <= sel_count;
    end

    assign count_out = count_out_q;

endmodule

// File: tb/tb_us_timer_bank.sv
// tb_us_timer_bank: directed scenario bench for us_timer_bank (NUM_TIMERS=4, CLKS_PER_US=50)
module tb_us_timer_bank;

    localparam int NT  = 4;
    localparam int CPU = 50;

    logic          sysclk      = 1'b0;
    logic          sysreset_n  = 1'b0;
    logic [15:0]   data_in     = '0;
    logic [NT-1:0] load        = '0;
    logic [NT-1:0] periodic    = '0;
    logic [3:0]    read_select = '0;
    logic [15:0]   count_out;
    logic [NT-1:0] expired;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ph        = 0;

    us_timer_bank #(.NUM_TIMERS(NT), .CLKS_PER_US(CPU)) dut (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .data_in    (data_in),
        .load       (load),
        .periodic   (periodic),
        .read_select(read_select),
        .count_out  (count_out),
        .expired    (expired)
    );

    always #5 sysclk = ~sysclk;

    // reference phase of the microsecond divider
    always @(posedge sysclk) ph <= !sysreset_n ? 0 : (ph == CPU - 1 ? 0 : ph + 1);

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge sysclk);
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (ph != p && n < 2 * CPU) begin
            step();
            n++;
        end
        total_cnt++;
        if (ph !== p) $display("FAIL wait_phase: phase %0d required %0d", ph, p);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        sysreset_n = 1'b0;
        load = '1;
        data_in = 16'd5;
        repeat (3) step();
        total_cnt++;
        if (expired !== 4'b0000) $display("FAIL reset_expired: got %b required 0000", expired);
        else pass_cnt++;
        total_cnt++;
        if (count_out !== 16'd0) $display("FAIL reset_count: got %0d required 0", count_out);
        else pass_cnt++;
        load = '0;
        sysreset_n = 1'b1;
        repeat (60) step();
        total_cnt++;
        if (expired !== 4'b0000) $display("FAIL idle_expired: got %b required 0000", expired);
        else pass_cnt++;
        total_cnt++;
        if (count_out !== 16'd0) $display("FAIL idle_count: got %0d required 0", count_out);
        else pass_cnt++;
    endtask

    task automatic test_oneshot();
        int seq[$];
        int exp_seq[5];
        int rise;
        int others_bad;
        logic [15:0] last;
        exp_seq = '{0, 3, 2, 1, 0};
        rise = -1;
        others_bad = 0;
        read_select = 4'd0;
        data_in = 16'd3;
        load = 4'b0001;
        step();
        load = '0;
        last = count_out;
        seq.push_back(int'(count_out));
        for (int c = 1; c <= 200; c++) begin
            step();
            if (count_out !== last) begin
                seq.push_back(int'(count_out));
                last = count_out;
            end
            if (expired[3:1] !== 3'b000) others_bad++;
            if (rise < 0 && expired[0] === 1'b1) rise = c;
        end
        total_cnt++;
        if (rise < 101 || rise > 150) $display("FAIL oneshot_latency: rose after %0d cycles required 101..150", rise);
        else pass_cnt++;
        total_cnt++;
        if (seq.size() != 5) $display("FAIL oneshot_seq_len: got %0d values required 5", seq.size());
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ((i < seq.size() ? seq[i] : -1) != exp_seq[i])
                $display("FAIL oneshot_seq[%0d]: got %0d required %0d", i, (i < seq.size() ? seq[i] : -1), exp_seq[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (others_bad != 0) $display("FAIL oneshot_others: %0d cycles with other bits set required 0", others_bad);
        else pass_cnt++;
        total_cnt++;
        if (expired[0] !== 1'b1) $display("FAIL oneshot_held: got %b required 1", expired[0]);
        else pass_cnt++;
    endtask

    task automatic test_zero_load();
        read_select = 4'd1;
        data_in = 16'd0;
        load = 4'b0010;
        step();
        load = '0;
        total_cnt++;
        if (expired[1] !== 1'b1) $display("FAIL zero_load_expired: got %b required 1", expired[1]);
        else pass_cnt++;
        data_in = 16'd5;
        load = 4'b0010;
        step();
        load = '0;
        total_cnt++;
        if (expired[1] !== 1'b0) $display("FAIL reload_clears: got %b required 0", expired[1]);
        else pass_cnt++;
        step();
        total_cnt++;
        if (count_out !== 16'd5) $display("FAIL reload_count: got %0d required 5", count_out);
        else pass_cnt++;
    endtask

    task automatic test_tick_coincident();
        read_select = 4'd2;
        wait_phase(CPU - 1);
        data_in = 16'd1;
        load = 4'b0100;
        step();
        load = '0;
        total_cnt++;
        if (expired[2] !== 1'b0) $display("FAIL coinc_no_early: got %b required 0", expired[2]);
        else pass_cnt++;
        step();
        total_cnt++;
        if (count_out !== 16'd1) $display("FAIL coinc_count: got %0d required 1", count_out);
        else pass_cnt++;
        for (int c = 2; c <= 49; c++) step();
        total_cnt++;
        if (expired[2] !== 1'b0) $display("FAIL coinc_before: got %b required 0 at 49", expired[2]);
        else pass_cnt++;
        step();
        total_cnt++;
        if (expired[2] !== 1'b1) $display("FAIL coinc_expire: got %b required 1 at 50", expired[2]);
        else pass_cnt++;
    endtask

    task automatic test_multi_load();
        int rise;
        rise = -1;
        read_select = 4'd0;
        data_in = 16'd2;
        load = 4'b0101;
        step();
        load = '0;
        total_cnt++;
        if ((expired & 4'b0101) !== 4'b0000) $display("FAIL multi_cleared: got %b required x0x0", expired);
        else pass_cnt++;
        for (int c = 1; c <= 120 && rise < 0; c++) begin
            step();
            if ((expired & 4'b0101) !== 4'b0000) rise = c;
        end
        total_cnt++;
        if ((expired & 4'b0101) !== 4'b0101) $display("FAIL multi_same_cycle: got %b required 0101 mask", expired & 4'b0101);
        else pass_cnt++;
        total_cnt++;
        if (rise < 51 || rise > 100) $display("FAIL multi_latency: rose after %0d cycles required 51..100", rise);
        else pass_cnt++;
    endtask

    task automatic test_periodic();
        int rises[$];
        int highs;
        logic prev;
        highs = 0;
        read_select = 4'd0;
        data_in = 16'd4;
        periodic = 4'b0001;
        load = 4'b0001;
        step();
        load = '0;
        periodic = '0;
        prev = expired[0];
        for (int c = 1; c <= 1300; c++) begin
            step();
            if (expired[0] === 1'b1) highs++;
            if (expired[0] === 1'b1 && prev !== 1'b1) rises.push_back(c);
            prev = expired[0];
`ifdef US_TIMER_AUTORELOAD_EN
            if (rises.size() >= 5 && c >= rises[4] + 3) break;
`else
            if (c >= 1100) break;
`endif
        end
        total_cnt++;
        if (rises.size() == 0 || rises[0] < 151 || rises[0] > 200)
            $display("FAIL periodic_first: rose after %0d cycles required 151..200", rises.size() ? rises[0] : -1);
        else pass_cnt++;
`ifdef US_TIMER_AUTORELOAD_EN
        total_cnt++;
        if (rises.size() != 5) $display("FAIL periodic_pulses: got %0d pulses required 5", rises.size());
        else pass_cnt++;
        for (int i = 1; i < 5; i++) begin
            total_cnt++;
            if (i >= rises.size() || rises[i] - rises[i-1] != 200)
                $display("FAIL periodic_gap[%0d]: got %0d cycles required 200", i, i < rises.size() ? rises[i] - rises[i-1] : -1);
            else pass_cnt++;
        end
        total_cnt++;
        if (highs != 5) $display("FAIL periodic_width: got %0d high cycles required 5", highs);
        else pass_cnt++;
`else
        total_cnt++;
        if (rises.size() != 1) $display("FAIL oneshot_rises: got %0d rising edges required 1", rises.size());
        else pass_cnt++;
        total_cnt++;
        if (expired[0] !== 1'b1) $display("FAIL oneshot_hold: got %b required 1", expired[0]);
        else pass_cnt++;
`endif
    endtask

    task automatic test_read_select();
        wait_phase(0);
        data_in = 16'd300;
        load = 4'b0010;
        read_select = 4'd1;
        step();
        load = '0;
        step();
        total_cnt++;
        if (count_out !== 16'd300) $display("FAIL sel1_count: got %0d required 300", count_out);
        else pass_cnt++;
        read_select = 4'd5;
        step();
        total_cnt++;
        if (count_out !== 16'd0) $display("FAIL sel5_zero: got %0d required 0", count_out);
        else pass_cnt++;
        read_select = 4'd15;
        step();
        total_cnt++;
        if (count_out !== 16'd0) $display("FAIL sel15_zero: got %0d required 0", count_out);
        else pass_cnt++;
        read_select = 4'd1;
        step();
        total_cnt++;
        if (count_out !== 16'd300) $display("FAIL sel1_back: got %0d required 300", count_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_midcount();
        int late;
        late = 0;
        read_select = 4'd3;
        data_in = 16'd1000;
        load = 4'b1000;
        step();
        load = '0;
        repeat (500 * CPU) step();
        total_cnt++;
        if (count_out < 16'd500 || count_out > 16'd501) $display("FAIL midcount_value: got %0d required 500..501", count_out);
        else pass_cnt++;
        sysreset_n = 1'b0;
        step();
        sysreset_n = 1'b1;
        total_cnt++;
        if (expired !== 4'b0000) $display("FAIL midreset_expired: got %b required 0000", expired);
        else pass_cnt++;
        total_cnt++;
        if (count_out !== 16'd0) $display("FAIL midreset_count: got %0d required 0", count_out);
        else pass_cnt++;
        for (int c = 0; c < 30000; c++) begin
            step();
            if (expired !== 4'b0000) late++;
        end
        total_cnt++;
        if (late != 0) $display("FAIL midreset_no_expiry: %0d cycles with expiry required 0", late);
        else pass_cnt++;
        total_cnt++;
        if (count_out !== 16'd0) $display("FAIL midreset_stays_zero: got %0d required 0", count_out);
        else pass_cnt++;
    endtask

    initial begin
        step();
        test_reset();
        test_oneshot();
        test_zero_load();
        test_tick_coincident();
        test_multi_load();
        test_periodic();
        test_read_select();
        test_reset_midcount();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
